// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared definitions for the instruction-fetch stage. Provides
//               the fetch FSM state encoding, the PC increment and the
//               instruction word used when IF/ID carries no real instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Fetch FSM encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;  // reset state, no request
  localparam logic [1:0] ST_FETCH = 2'd1;  // request outstanding to imem
  localparam logic [1:0] ST_HOLD  = 2'd2;  // fetched word parked in skid

  // Byte distance between consecutive instructions
  localparam int unsigned PC_STEP = 4;

  // Instruction word held in IF/ID when it carries nothing real
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Priority is flush > load > hold.
//               A flush marks the slot empty and parks a NOP in it; the
//               pc4 field is left as it was since nothing reads it while
//               the slot is invalid.
// Ports       : clk, reset (async, active-low)
//               flush        - empty the register
//               load         - capture load_instru / load_pc4, mark valid
//               load_instru  - instruction to capture
//               load_pc4     - address of that instruction + 4
//               valid/instru/pc4 - register contents
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_instru,
  input  logic [ADDR_W-1:0] load_pc4,
  output logic              valid,
  output logic [DATA_W-1:0] instru,
  output logic [ADDR_W-1:0] pc4
);

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] instru_q, instru_d;
  logic [ADDR_W-1:0] pc4_q,    pc4_d;

  always_comb begin
    valid_d  = valid_q;
    instru_d = instru_q;
    pc4_d    = pc4_q;
    if (flush) begin
      valid_d  = 1'b0;
      instru_d = DATA_W'(NOP_INSTR);
    end else if (load) begin
      valid_d  = 1'b1;
      instru_d = load_instru;
      pc4_d    = load_pc4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      instru_q <= DATA_W'(NOP_INSTR);
      pc4_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      instru_q <= instru_d;
      pc4_q    <= pc4_d;
    end
  end

  assign valid  = valid_q;
  assign instru = instru_q;
  assign pc4    = pc4_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, issues one request at a
//               time to instruction memory, parks a fetched word in a skid
//               buffer while decode stalls, and discards wrong-path fetches
//               on redirects (including redirects that arrive while a
//               request is still waiting for its acknowledge).
// Ports       : clk, reset (async, active-low)
//               imem_req/imem_addr     - fetch request, address = PC
//               imem_ack/imem_rdata    - request completion and data
//               stall                  - decode cannot accept, IF/ID holds
//               redirect/redirect_pc   - taken branch/jump and its target
//               if_id_valid/if_id_instru/if_id_pc4 - IF/ID register
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instru,
  output logic [ADDR_W-1:0] if_id_pc4
);

  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(PC_STEP);
  // Instructions are word aligned; the low two target bits are dropped
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] pc_q,      pc_d;
  logic              pend_q,    pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] skid_q,    skid_d;

  logic              ifid_flush;
  logic              ifid_load;
  logic [DATA_W-1:0] ifid_ld_instru;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_pc;

  // Wraps modulo 2^ADDR_W by construction
  assign pc_plus4  = pc_q + PC_INC;
  assign target_pc = redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;
    skid_d         = skid_q;
    ifid_flush     = 1'b0;
    ifid_load      = 1'b0;
    ifid_ld_instru = skid_q;

    case (state_q)
      ST_IDLE: begin
        // A stale ack arriving here belongs to an abandoned request
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // Redirect empties IF/ID; a missing ack with decode ready is a bubble
        if (redirect || (!imem_ack && !stall)) begin
          ifid_flush = 1'b1;
        end

        if (imem_ack) begin
          if (redirect) begin
            // Newest redirect wins over any older pending target
            pc_d   = target_pc;
            pend_d = 1'b0;
          end else if (pend_q) begin
            // Word belongs to the wrong path; start the pending target
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else if (!stall) begin
            ifid_load      = 1'b1;
            ifid_ld_instru = imem_rdata;
            pc_d           = pc_plus4;
          end else begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          // imem_addr must stay put until the ack, so remember the target
          pend_d    = 1'b1;
          pend_pc_d = target_pc;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          skid_d     = DATA_W'(NOP_INSTR);
          pc_d       = target_pc;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          // pc still addresses the parked word, so pc+4 is its pc4
          ifid_load      = 1'b1;
          ifid_ld_instru = skid_q;
          pc_d           = pc_plus4;
          state_d        = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      skid_q    <= DATA_W'(NOP_INSTR);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      skid_q    <= skid_d;
    end
  end

  // Pure state decode: no input reaches imem_req combinationally
  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .flush       (ifid_flush),
    .load        (ifid_load),
    .load_instru (ifid_ld_instru),
    .load_pc4    (pc_plus4),
    .valid       (if_id_valid),
    .instru      (if_id_instru),
    .pc4         (if_id_pc4)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A small memory model
//               answers requests after a programmable number of wait cycles;
//               the expected IF/ID contents are queued as stimulus is set up
//               and compared whenever an entry leaves IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instru;
  logic [31:0] if_id_pc4;

  typedef struct packed {
    logic [31:0] instru;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic ack_norm  = 1'b0;
  logic force_ack = 1'b0;

  fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_instru (if_id_instru),
    .if_id_pc4    (if_id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h0001_0001) ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [31:0] instru, input logic [31:0] pc4);
    exp_t e;
    e.instru = instru;
    e.pc4    = pc4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    imem_req,     0);
    check_eq({tag, "_addr"},   imem_addr,    32'h0);
    check_eq({tag, "_valid"},  if_id_valid,  0);
    check_eq({tag, "_instru"}, if_id_instru, 32'h0);
    check_eq({tag, "_pc4"},    if_id_pc4,    32'h0);
  endtask

  // Memory model: ack after ack_delay wait cycles; force_ack models a stale ack
  always begin
    @(posedge clk);
    #2;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        ack_norm = 1'b1;
        wait_cnt = 0;
      end else begin
        ack_norm = 1'b0;
        wait_cnt++;
      end
    end else begin
      ack_norm = 1'b0;
      wait_cnt = 0;
    end
  end

  assign imem_ack   = ack_norm | force_ack;
  assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'hDEAD_DEAD;

  // An entry leaves IF/ID when decode accepts it or a redirect kills it
  always @(negedge clk) begin
    if (reset && if_id_valid && (!stall || redirect)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("ifid_instru", if_id_instru, e.instru);
        check_eq("ifid_pc4",    if_id_pc4,    e.pc4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    check_reset_outputs("reset");

    // Zero-wait stream from address 0
    @(negedge clk);
    reset = 1'b1;
    push_exp(word_at(32'h0), 32'h4);
    push_exp(word_at(32'h4), 32'h8);
    step();
    check_eq("first_req",   imem_req,    1);
    check_eq("first_addr",  imem_addr,   32'h0);
    check_eq("first_valid", if_id_valid, 0);
    step();
    check_eq("s1_addr",   imem_addr,    32'h4);
    check_eq("s1_valid",  if_id_valid,  1);
    check_eq("s1_instru", if_id_instru, 32'h2001_0005);
    check_eq("s1_pc4",    if_id_pc4,    32'h4);
    step();
    check_eq("s2_addr", imem_addr, 32'h8);
    check_eq("s2_pc4",  if_id_pc4, 32'h8);

    // Stall while the word at 8 is acknowledged
    stall = 1'b1;
    push_exp(word_at(32'h8), 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_req",    imem_req,     0);
      check_eq("stall_pc4",    if_id_pc4,    32'h8);
      check_eq("stall_instru", if_id_instru, word_at(32'h4));
    end
    stall = 1'b0;
    push_exp(word_at(32'hC), 32'h10);
    step();
    check_eq("unstall_instru", if_id_instru, word_at(32'h8));
    check_eq("unstall_pc4",    if_id_pc4,    32'hC);
    check_eq("unstall_addr",   imem_addr,    32'hC);
    check_eq("unstall_req",    imem_req,     1);
    step();
    check_eq("s3_addr", imem_addr, 32'h10);

    // Two redirects while the fetch at 16 waits for its ack
    ack_delay   = 3;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    check_eq("pend1_addr",  imem_addr,   32'h10);
    check_eq("pend1_valid", if_id_valid, 0);
    redirect_pc = 32'h80;
    step();
    check_eq("pend2_addr",  imem_addr,   32'h10);
    check_eq("pend2_valid", if_id_valid, 0);
    redirect = 1'b0;
    step();
    check_eq("pend3_addr",  imem_addr,   32'h10);
    check_eq("pend3_valid", if_id_valid, 0);
    step();
    check_eq("pend_target", imem_addr,   32'h80);
    check_eq("pend4_valid", if_id_valid, 0);
    ack_delay = 0;
    push_exp(word_at(32'h80), 32'h84);
    step();
    check_eq("tgt_valid", if_id_valid, 1);
    check_eq("tgt_pc4",   if_id_pc4,   32'h84);

    // Redirect, ack and stall in the same cycle
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    stall       = 1'b1;
    step();
    check_eq("ras_valid", if_id_valid, 0);
    check_eq("ras_addr",  imem_addr,   32'h200);
    check_eq("ras_req",   imem_req,    1);
    redirect = 1'b0;
    stall    = 1'b0;
    push_exp(word_at(32'h200), 32'h204);
    step();
    check_eq("ras_next_valid", if_id_valid, 1);
    check_eq("ras_next_pc4",   if_id_pc4,   32'h204);
    check_eq("ras_next_addr",  imem_addr,   32'h204);

    // Reset while a request is outstanding and IF/ID holds a valid word
    stall     = 1'b1;
    ack_delay = 5;
    step();
    check_eq("mid_req",   imem_req,     1);
    check_eq("mid_addr",  imem_addr,    32'h204);
    check_eq("mid_valid", if_id_valid,  1);
    check_eq("mid_q",     exp_q.size(), 1);
    @(negedge clk);
    reset     = 1'b0;
    force_ack = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    step();
    step();
    check_eq("inrst_req", imem_req, 0);
    @(negedge clk);
    reset     = 1'b1;
    stall     = 1'b0;
    ack_delay = 0;
    step();
    check_eq("late_ack_req",   imem_req,    1);
    check_eq("late_ack_addr",  imem_addr,   32'h0);
    check_eq("late_ack_valid", if_id_valid, 0);
    force_ack = 1'b0;
    push_exp(word_at(32'h0), 32'h4);
    step();
    check_eq("rst2_valid", if_id_valid, 1);
    check_eq("rst2_pc4",   if_id_pc4,   32'h4);

    // Misaligned redirect to the top word, then wrap to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    push_exp(word_at(32'hFFFF_FFFC), 32'h0);
    step();
    check_eq("wrap_addr",  imem_addr,   32'hFFFF_FFFC);
    check_eq("wrap_valid", if_id_valid, 0);
    redirect = 1'b0;
    step();
    check_eq("wrap_pc4",       if_id_pc4,   32'h0);
    check_eq("wrap_valid2",    if_id_valid, 1);
    check_eq("wrap_next_addr", imem_addr,   32'h0);

    // Drain: hold the word one cycle, then release with memory silent
    ack_delay = 100;
    stall     = 1'b1;
    step();
    check_eq("drain_valid", if_id_valid,  1);
    check_eq("drain_q",     exp_q.size(), 1);
    stall = 1'b0;
    step();
    check_eq("end_q",     exp_q.size(), 0);
    check_eq("end_valid", if_id_valid,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the segmented processor. Owns the program counter and drives a request/acknowledge port to instruction memory. Holds fetched instructions through decode stalls and discards wrong-path fetches on branch/jump redirects. Its output is the IF/ID pipeline register consumed by decode: control, register bank read and sign extension.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width (byte addresses)
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address; equals PC
- imem_ack  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  DATA_W  fetched instruction
- stall  in  1  decode cannot accept; IF/ID must hold
- redirect  in  1  taken branch/jump; flush wrong path
- redirect_pc  in  ADDR_W  redirect target
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instru  out  DATA_W  IF/ID instruction
- if_id_pc4  out  ADDR_W  address of that instruction + 4

## Operation
- **States:**
  - IDLE: reset state, imem_req=0.
  - FETCH: imem_req=1.
  - HOLD: imem_req=0; an instruction is parked in the skid buffer.
- **IDLE → FETCH:** unconditionally, on the first clock edge after reset deasserts.
- **FETCH, ack=1, no redirect, no pending redirect:**
  - stall=0: IF/ID ← {1, rdata, pc+4}; pc ← pc+4; stay in FETCH.
  - stall=1: skid buffer ← rdata; go to HOLD; IF/ID unchanged.
- **FETCH, ack=0:**
  - stall=0: if_id_valid ← 0 (bubble).
  - stall=1: IF/ID holds.
- **HOLD:**
  - stall=0: IF/ID ← {1, skid, pc+4}; pc ← pc+4; go to FETCH.
  - stall=1: remain in HOLD.
- **Redirect, general rules:**
  - Redirect has priority over stall.
  - if_id_valid ← 0 on the edge where redirect=1.
- **Redirect in FETCH, ack=1 same cycle:** discard rdata; pc ← redirect_pc; stay in FETCH.
- **Redirect in FETCH, ack=0:**
  - imem_addr must stay stable until ack.
  - Set pending flag; pending_pc ← redirect_pc. A later redirect overwrites pending_pc.
  - On the ack: discard rdata; pc ← pending_pc; clear pending flag.
  - The pending flag also suppresses IF/ID loading.
- **Redirect in HOLD:** drop the skid buffer; pc ← redirect_pc; go to FETCH.
- **Handshake rules:**
  - While imem_req=1 and ack has not arrived, imem_addr is constant.
  - At most one outstanding request.
  - Ack in the same cycle as request is legal (zero-wait memory).
- **Arithmetic:** pc+4 is modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0 without a flag. pc[1:0] is always 0; redirect_pc[1:0] is ignored (forced to 0).

## Timing
- **Reset values** (asynchronous, all outputs):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - if_id_valid=0, if_id_instru=0, if_id_pc4=0.
  - Pending flag=0, skid=0.
- **Reset mid-request:** the request is abandoned immediately. A late ack after reset is ignored while in IDLE.
- **Latency:** ack in cycle N, stall=0 → IF/ID valid in cycle N+1.
- **Throughput:** zero-wait memory gives one instruction per cycle.
- **Redirect:** asserted in cycle N → first target request no earlier than N+1. Exactly one bubble if memory is zero-wait and nothing is outstanding.
- **imem_req timing:** a combinational decode of state only; no input-to-output combinational path on imem_req.

## Structure
- **Shared package:**
  - State enum {IDLE, FETCH, HOLD}.
  - PC_STEP=4.
  - NOP_INSTR=32'h0000_0000.
- **Sub-module if_id_reg:** IF/ID register with load, hold and flush controls. Flush beats load beats hold.
- **Local to fetch_stage:** PC, pending flag and skid buffer.

## Test plan
- **Reset:** release reset; memory zero-wait returns 32'h2001_0005 at 0 → imem_addr=0 in the first FETCH cycle; next cycle if_id_valid=1, if_id_instru=32'h2001_0005, if_id_pc4=4.
- **Stream:** zero-wait memory for 4 cycles → addresses 0, 4, 8, 12 on consecutive cycles; if_id_pc4 sequence 4, 8, 12, 16.
- **Stall:** stall=1 for 3 cycles while ack arrives at addr 8 → state HOLD, imem_req=0, IF/ID unchanged; stall drops → IF/ID gets the addr-8 word, if_id_pc4=12; next fetch is addr 12.
- **Pending redirect:** ack delayed 3 cycles at addr 16; redirect with redirect_pc=32'h40 in wait cycle 1, then 32'h80 in wait cycle 2 → imem_addr stays 16 until ack; the word at 16 is discarded; next imem_addr=32'h80; if_id_valid=0 throughout.
- **Redirect + ack + stall:** redirect, ack and stall all 1 in the same cycle → data discarded; if_id_valid=0; next imem_addr=redirect_pc.
- **Wrap and reset mid-request:**
  - Redirect to 32'hFFFF_FFFC → if_id_pc4=0; next address 0.
  - Assert reset while a request is outstanding → all outputs return to reset values immediately.
